// File: rtl/maze_pkg.sv
// maze_pkg: shared types, state encodings, direction offsets and turn helpers
// for the maze solver. Directions: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1).
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  // Solver FSM encoding kept as plain constants for legacy tool compatibility.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_SOLVED = 2'd2;
  localparam state_t ST_FAIL   = 2'd3;

  // Per-direction coordinate offsets, indexed by dir_t.
  localparam logic signed [1:0] DIR_DX [4] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1};
  localparam logic signed [1:0] DIR_DY [4] = '{-2'sd1, 2'sd0, 2'sd1, 2'sd0};

  function automatic dir_t turn_right(input dir_t h);
    return dir_t'(2'(h + 2'd1));
  endfunction

  function automatic dir_t turn_left(input dir_t h);
    return dir_t'(2'(h + 2'd3));
  endfunction

  function automatic dir_t turn_back(input dir_t h);
    return dir_t'(2'(h + 2'd2));
  endfunction

endpackage

// File: rtl/maze_dir_sel.sv
// maze_dir_sel: combinational right-hand-rule move selector.
// Ports:
//   maze          - maze[y][x], 1 = open cell
//   pos_x, pos_y  - current cell
//   heading       - current heading
//   next_dir_c    - chosen heading (first open of right, forward, left, back)
//   move_valid_c  - at least one neighbour is open and in bounds
//   next_x_c/_y_c - cell in the chosen direction
module maze_dir_sel
  import maze_pkg::*;
#(
  parameter int unsigned size = 16,
  parameter int unsigned N    = $clog2(size)
) (
  input  logic [size-1:0] maze [size],
  input  logic [N-1:0]    pos_x,
  input  logic [N-1:0]    pos_y,
  input  dir_t            heading,
  output dir_t            next_dir_c,
  output logic            move_valid_c,
  output logic [N-1:0]    next_x_c,
  output logic [N-1:0]    next_y_c
);

  // Two extra bits: one for the +1 overflow past size-1, one for sign (-1).
  localparam int unsigned CW = N + 2;
  localparam logic [CW-2:0] MAX_COORD = (CW-1)'(size - 1);

  logic signed [CW-1:0] nx_c [4];
  logic signed [CW-1:0] ny_c [4];
  logic [3:0]           open_c;
  dir_t                 cand_c [4];

  // Probe all four absolute neighbours; out-of-bounds counts as a wall.
  always_comb begin
    open_c = '0;
    for (int d = 0; d < 4; d++) begin
      nx_c[d] = $signed({2'b00, pos_x}) + CW'(DIR_DX[d]);
      ny_c[d] = $signed({2'b00, pos_y}) + CW'(DIR_DY[d]);
      if (!nx_c[d][CW-1] && !ny_c[d][CW-1] &&
          (nx_c[d][CW-2:0] <= MAX_COORD) && (ny_c[d][CW-2:0] <= MAX_COORD)) begin
        open_c[d] = maze[ny_c[d][N-1:0]][nx_c[d][N-1:0]];
      end
    end
  end

  // Pick the first open candidate in right, forward, left, back order.
  always_comb begin
    cand_c[0]    = turn_right(heading);
    cand_c[1]    = heading;
    cand_c[2]    = turn_left(heading);
    cand_c[3]    = turn_back(heading);
    move_valid_c = 1'b0;
    next_dir_c   = heading;
    next_x_c     = pos_x;
    next_y_c     = pos_y;
    for (int k = 0; k < 4; k++) begin
      if (!move_valid_c && open_c[cand_c[k]]) begin
        move_valid_c = 1'b1;
        next_dir_c   = cand_c[k];
        next_x_c     = nx_c[cand_c[k]][N-1:0];
        next_y_c     = ny_c[cand_c[k]][N-1:0];
      end
    end
  end

endmodule

// File: rtl/maze_solver.sv
// maze_solver: right-hand wall-follower over the generator's finished maze.
// Ports:
//   clk, rst                  - clock, async active-low reset
//   maze, maze_done           - read-only maze array and generator done
//   start, start_x/y, goal_x/y - solve request and endpoints
//   busy                      - solving in progress
//   pos_x, pos_y, step_valid  - current cell, one pulse per move
//   steps                     - moves made so far
//   solved, fail              - sticky terminal flags
module maze_solver
  import maze_pkg::*;
#(
  parameter int unsigned size = 16,
  parameter int unsigned N    = $clog2(size),
  parameter int unsigned SW   = 2 * N + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] maze [size],
  input  logic            maze_done,
  input  logic            start,
  input  logic [N-1:0]    start_x,
  input  logic [N-1:0]    start_y,
  input  logic [N-1:0]    goal_x,
  input  logic [N-1:0]    goal_y,
  output logic            busy,
  output logic [N-1:0]    pos_x,
  output logic [N-1:0]    pos_y,
  output logic            step_valid,
  output logic [SW-1:0]   steps,
  output logic            solved,
  output logic            fail
);

  localparam logic [SW-1:0] STEP_LIMIT = SW'(4 * size * size);

  state_t        state_q, state_d;
  logic [N-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [N-1:0]  goal_x_q, goal_x_d, goal_y_q, goal_y_d;
  dir_t          heading_q, heading_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          busy_q, busy_d;
  logic          step_valid_q, step_valid_d;
  logic          solved_q, solved_d;
  logic          fail_q, fail_d;

  dir_t         next_dir_c;
  logic         move_valid_c;
  logic [N-1:0] next_x_c, next_y_c;

  maze_dir_sel #(.size(size), .N(N)) u_dir_sel (
    .maze         (maze),
    .pos_x        (pos_x_q),
    .pos_y        (pos_y_q),
    .heading      (heading_q),
    .next_dir_c   (next_dir_c),
    .move_valid_c (move_valid_c),
    .next_x_c     (next_x_c),
    .next_y_c     (next_y_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    goal_x_d     = goal_x_q;
    goal_y_d     = goal_y_q;
    heading_d    = heading_q;
    steps_d      = steps_q;
    busy_d       = busy_q;
    step_valid_d = 1'b0;
    solved_d     = solved_q;
    fail_d       = fail_q;

    case (state_q)
      ST_RUN: begin
        if ((pos_x_q == goal_x_q) && (pos_y_q == goal_y_q)) begin
          state_d  = ST_SOLVED;
          solved_d = 1'b1;
          busy_d   = 1'b0;
        end else if (!maze[pos_y_q][pos_x_q] || (steps_q == STEP_LIMIT) || !move_valid_c) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          pos_x_d      = next_x_c;
          pos_y_d      = next_y_c;
          heading_d    = next_dir_c;
          steps_d      = steps_q + SW'(1);
          step_valid_d = 1'b1;
        end
      end
      default: begin
        // IDLE, SOLVED and FAIL all accept a new start once the maze is ready.
        if (start && maze_done) begin
          state_d   = ST_RUN;
          pos_x_d   = start_x;
          pos_y_d   = start_y;
          goal_x_d  = goal_x;
          goal_y_d  = goal_y;
          heading_d = DIR_E;
          steps_d   = '0;
          busy_d    = 1'b1;
          solved_d  = 1'b0;
          fail_d    = 1'b0;
        end
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      goal_x_q     <= '0;
      goal_y_q     <= '0;
      heading_q    <= DIR_E;
      steps_q      <= '0;
      busy_q       <= 1'b0;
      step_valid_q <= 1'b0;
      solved_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      goal_x_q     <= goal_x_d;
      goal_y_q     <= goal_y_d;
      heading_q    <= heading_d;
      steps_q      <= steps_d;
      busy_q       <= busy_d;
      step_valid_q <= step_valid_d;
      solved_q     <= solved_d;
      fail_q       <= fail_d;
    end
  end

  assign busy       = busy_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign step_valid = step_valid_q;
  assign steps      = steps_q;
  assign solved     = solved_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver: directed scoreboard bench for maze_solver on a 4x4 maze.
module tb_maze_solver;

  localparam int unsigned SIZE = 4;
  localparam int unsigned N    = 2;
  localparam int unsigned SW   = 7;

  typedef struct {
    int x;
    int y;
  } pos_t;

  typedef struct {
    int solved;
    int fail;
    int steps;
  } res_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] maze [SIZE];
  logic            maze_done;
  logic            start;
  logic [N-1:0]    start_x, start_y, goal_x, goal_y;
  logic            busy;
  logic [N-1:0]    pos_x, pos_y;
  logic            step_valid;
  logic [SW-1:0]   steps;
  logic            solved;
  logic            fail;

  int checks   = 0;
  int failures = 0;

  pos_t exp_pos[$];
  res_t exp_res[$];

  always #5 clk = ~clk;

  maze_solver #(.size(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .maze       (maze),
    .maze_done  (maze_done),
    .start      (start),
    .start_x    (start_x),
    .start_y    (start_y),
    .goal_x     (goal_x),
    .goal_y     (goal_y),
    .busy       (busy),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .step_valid (step_valid),
    .steps      (steps),
    .solved     (solved),
    .fail       (fail)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_pos(input int x, input int y);
    pos_t p;
    p.x = x;
    p.y = y;
    exp_pos.push_back(p);
  endtask

  task automatic push_res(input int s, input int f, input int n);
    res_t r;
    r.solved = s;
    r.fail   = f;
    r.steps  = n;
    exp_res.push_back(r);
  endtask

  task automatic push_open_field();
    int xs [6] = '{0, 0, 0, 1, 2, 3};
    int ys [6] = '{1, 2, 3, 3, 3, 3};
    for (int i = 0; i < 6; i++) push_pos(xs[i], ys[i]);
    push_res(1, 0, 6);
  endtask

  task automatic set_maze(input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [3:0] r3);
    maze[0] = r0;
    maze[1] = r1;
    maze[2] = r2;
    maze[3] = r3;
  endtask

  task automatic issue_start(input int sx, input int sy, input int gx, input int gy);
    @(negedge clk);
    start   = 1'b1;
    start_x = N'(sx);
    start_y = N'(sy);
    goal_x  = N'(gx);
    goal_y  = N'(gy);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a solve, optionally poke a second start mid-run, wait for completion.
  task automatic run(input int sx, input int sy, input int gx, input int gy, input bit poke);
    bit done;
    issue_start(sx, sy, gx, gy);
    check("busy_after_start", int'(busy), 1);
    if (poke) issue_start(3, 3, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) check("run_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops expected moves on step_valid and results on busy falling.
  initial begin
    bit   busy_prev;
    pos_t p;
    res_t r;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0;
      end else begin
        if (step_valid) begin
          if (exp_pos.size() == 0) begin
            check("unexpected_step", 1, 0);
          end else begin
            p = exp_pos.pop_front();
            check("pos_x", int'(pos_x), p.x);
            check("pos_y", int'(pos_y), p.y);
          end
        end
        if (busy_prev && !busy) begin
          if (exp_res.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            r = exp_res.pop_front();
            check("solved", int'(solved), r.solved);
            check("fail", int'(fail), r.fail);
            check("steps", int'(steps), r.steps);
          end
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    bit hit;
    maze_done = 1'b1;
    start     = 1'b0;
    start_x   = '0;
    start_y   = '0;
    goal_x    = '0;
    goal_y    = '0;
    set_maze(4'b1111, 4'b1111, 4'b1111, 4'b1111);

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_step_valid", int'(step_valid), 0);
    check("rst_solved", int'(solved), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_steps", int'(steps), 0);
    check("rst_pos", int'({pos_y, pos_x}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Open field, with an ignored start issued while busy.
    push_open_field();
    run(0, 0, 3, 3, 1'b1);

    // Corridor along row 0.
    set_maze(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push_pos(1, 0);
    push_pos(2, 0);
    push_pos(3, 0);
    push_res(1, 0, 3);
    run(0, 0, 3, 0, 1'b0);

    // start == goal: solved with zero moves.
    set_maze(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    push_res(1, 0, 0);
    run(2, 2, 2, 2, 1'b0);

    // Closed start cell (1,1).
    set_maze(4'b1111, 4'b1101, 4'b1111, 4'b1111);
    push_res(0, 1, 0);
    run(1, 1, 3, 3, 1'b0);

    // Isolated start cell.
    set_maze(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    push_res(0, 1, 0);
    run(0, 0, 3, 3, 1'b0);

    // Unreachable goal: bounce between (1,0) and (0,0) until the step limit.
    set_maze(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) push_pos(1, 0);
      else            push_pos(0, 0);
    end
    push_res(0, 1, 64);
    run(0, 0, 3, 3, 1'b0);

    // start without maze_done is ignored; fail stays held.
    maze_done = 1'b0;
    set_maze(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    issue_start(0, 0, 3, 3);
    repeat (3) begin
      @(negedge clk);
      check("busy_no_done", int'(busy), 0);
    end
    check("fail_held", int'(fail), 1);
    maze_done = 1'b1;

    // Async reset after the second move of the open field.
    push_open_field();
    issue_start(0, 0, 3, 3);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (steps == SW'(2)) hit = 1'b1;
    end
    if (!hit) check("reach_step2_timeout", 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_step_valid", int'(step_valid), 0);
    check("arst_steps", int'(steps), 0);
    check("arst_pos", int'({pos_y, pos_x}), 0);
    check("arst_flags", int'({solved, fail}), 0);
    exp_pos.delete();
    exp_res.delete();
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Rerun gives the identical six-move result.
    push_open_field();
    run(0, 0, 3, 3, 1'b0);

    check("queues_drained", exp_pos.size() + exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
